sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 17 +
 rtl/sram_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side bus between one SRAM client (core LSU or loader DMA)
// and the SRAM arbiter: request fields in, completion pulse and data out.
interface sram_arbiter_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        err;
   logic [31:0] rdata;

   modport master (output req, we, size, addr, wdata,
                   input  ready, err, rdata);
   modport slave  (input  req, we, size, addr, wdata,
                   output ready, err, rdata);
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin SRAM arbiter. Word accesses go straight to
// memory; byte/halfword writes do a read-modify-write through MERGE.
// Illegal requests are answered with err after one cycle and never write.
module sram_arbiter #(
   parameter logic [31:0] SRAM_LIMIT = 32'h0000ffff
) (
   input  logic        clk,
   input  logic        rst,
   sram_arbiter_if.slave m0,
   sram_arbiter_if.slave m1,
   output logic [31:0] sram_addr,
   output logic [31:0] w_sram,
   output logic        w_sram_en,
   input  logic [31:0] r_sram
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] MERGE  = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]  state_r;
   logic        prio_r;      // 0: m0 wins a tie, 1: m1 wins a tie
   logic        gnt_r;       // 0: m0 owns the transaction, 1: m1
   logic        we_r;
   logic [1:0]  size_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic        m0_ready_r, m1_ready_r, m0_err_r, m1_err_r;
   logic [31:0] m0_rdata_r, m1_rdata_r;
   logic [31:0] sram_addr_r, w_sram_r;
   logic        w_sram_en_r;

   logic        any_req_s, grant_m1_s, sel_we_s, sel_illegal_s;
   logic [1:0]  sel_size_s;
   logic [31:0] sel_addr_s, sel_wdata_s;

   // Misaligned, reserved-size or out-of-range accesses are rejected.
   function automatic logic is_illegal(input logic [1:0] size, input logic [31:0] addr);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr[0];
         SZ_WORD: bad = (addr[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad | (addr > SRAM_LIMIT);
   endfunction

   // Extract the addressed lane(s) of a memory word, zero-extended.
   function automatic logic [31:0] read_lane(input logic [31:0] word, input logic [1:0] ofs,
                                             input logic [1:0] size);
      logic [31:0] sh_b, sh_h, res;
      sh_b = word >> {ofs, 3'b000};
      sh_h = word >> {ofs[1], 4'b0000};
      case (size)
         SZ_BYTE: res = {24'h000000, sh_b[7:0]};
         SZ_HALF: res = {16'h0000, sh_h[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // Replace the addressed lane(s) of a memory word with right-justified write data.
   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] ofs,
                                              input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] mask_b, mask_h, data_b, data_h, res;
      mask_b = 32'h000000ff << {ofs, 3'b000};
      mask_h = 32'h0000ffff << {ofs[1], 4'b0000};
      data_b = {24'h000000, wdata[7:0]} << {ofs, 3'b000};
      data_h = {16'h0000, wdata[15:0]} << {ofs[1], 4'b0000};
      case (size)
         SZ_BYTE: res = (word & ~mask_b) | data_b;
         SZ_HALF: res = (word & ~mask_h) | data_h;
         default: res = wdata;
      endcase
      return res;
   endfunction

   // Round-robin pick between the two requesters and mux the winner's fields.
   always_comb begin
      any_req_s  = m0.req | m1.req;
      grant_m1_s = 1'b0;
      if (m0.req && m1.req) begin
         grant_m1_s = prio_r;
      end else if (m1.req) begin
         grant_m1_s = 1'b1;
      end else begin
         grant_m1_s = 1'b0;
      end
      sel_we_s      = grant_m1_s ? m1.we    : m0.we;
      sel_size_s    = grant_m1_s ? m1.size  : m0.size;
      sel_addr_s    = grant_m1_s ? m1.addr  : m0.addr;
      sel_wdata_s   = grant_m1_s ? m1.wdata : m0.wdata;
      sel_illegal_s = is_illegal(sel_size_s, sel_addr_s);
   end

   // Transaction FSM; every output is a register so strobes and pulses are glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         prio_r      <= 1'b0;
         gnt_r       <= 1'b0;
         we_r        <= 1'b0;
         size_r      <= 2'b00;
         addr_r      <= 32'h00000000;
         wdata_r     <= 32'h00000000;
         m0_ready_r  <= 1'b0;
         m1_ready_r  <= 1'b0;
         m0_err_r    <= 1'b0;
         m1_err_r    <= 1'b0;
         m0_rdata_r  <= 32'h00000000;
         m1_rdata_r  <= 32'h00000000;
         sram_addr_r <= 32'h00000000;
         w_sram_r    <= 32'h00000000;
         w_sram_en_r <= 1'b0;
      end else begin
         m0_ready_r  <= 1'b0;
         m1_ready_r  <= 1'b0;
         m0_err_r    <= 1'b0;
         m1_err_r    <= 1'b0;
         w_sram_en_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  gnt_r       <= grant_m1_s;
                  prio_r      <= ~grant_m1_s;
                  we_r        <= sel_we_s;
                  size_r      <= sel_size_s;
                  addr_r      <= sel_addr_s;
                  wdata_r     <= sel_wdata_s;
                  sram_addr_r <= {sel_addr_s[31:2], 2'b00};
                  if (sel_illegal_s) begin
                     state_r <= RESP;
                     if (grant_m1_s) begin
                        m1_ready_r <= 1'b1;
                        m1_err_r   <= 1'b1;
                     end else begin
                        m0_ready_r <= 1'b1;
                        m0_err_r   <= 1'b1;
                     end
                  end else begin
                     state_r <= ACCESS;
                     if (sel_we_s && (sel_size_s == SZ_WORD)) begin
                        w_sram_en_r <= 1'b1;
                        w_sram_r    <= sel_wdata_s;
                     end else begin
                        w_sram_en_r <= 1'b0;
                     end
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (we_r && (size_r != SZ_WORD)) begin
                  state_r     <= MERGE;
                  w_sram_en_r <= 1'b1;
                  w_sram_r    <= merge_lane(r_sram, addr_r[1:0], size_r, wdata_r);
               end else begin
                  state_r <= RESP;
                  if (gnt_r) begin
                     m1_ready_r <= 1'b1;
                     if (!we_r) begin
                        m1_rdata_r <= read_lane(r_sram, addr_r[1:0], size_r);
                     end else begin
                        m1_rdata_r <= m1_rdata_r;
                     end
                  end else begin
                     m0_ready_r <= 1'b1;
                     if (!we_r) begin
                        m0_rdata_r <= read_lane(r_sram, addr_r[1:0], size_r);
                     end else begin
                        m0_rdata_r <= m0_rdata_r;
                     end
                  end
               end
            end
            MERGE: begin
               state_r <= RESP;
               if (gnt_r) begin
                  m1_ready_r <= 1'b1;
               end else begin
                  m0_ready_r <= 1'b1;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign m0.ready  = m0_ready_r;
   assign m1.ready  = m1_ready_r;
   assign m0.err    = m0_err_r;
   assign m1.err    = m1_err_r;
   assign m0.rdata  = m0_rdata_r;
   assign m1.rdata  = m1_rdata_r;
   assign sram_addr = sram_addr_r;
   assign w_sram    = w_sram_r;
   assign w_sram_en = w_sram_en_r;

endmodule
